// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional build macro: FETCH_PERFCNT_EN (address-wait performance counter).
package fetch_ctrl_pkg;

  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

  // One in-flight fetch: pc[34:3], cancel[2], exc[1], data_got[0]
  typedef struct packed {
    logic [31:0] pc;
    logic        cancel;
    logic        exc;
    logic        data_got;
  } fq_ent_t;

  function automatic fq_ent_t fq_make(input logic [31:0] pc, input logic cancel,
                                      input logic exc);
    fq_ent_t e;
    e.pc       = pc;
    e.cancel   = cancel;
    e.exc      = exc;
    e.data_got = exc;   // a faulting fetch never sees a bus response
    return e;
  endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// fetch_queue: DEPTH-entry circular buffer of in-flight fetches with
// flash-cancel and in-order response (data_got) tracking.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fq_ent_t     push_ent_i,
  input  logic        pop_i,
  input  logic        cancel_all_i,
  input  logic        data_ok_i,
  output logic [31:0] head_pc_o,
  output logic        head_cancel_o,
  output logic        head_exc_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  fq_ent_t          ent_q [DEPTH];
  fq_ent_t          ent_d [DEPTH];
  logic [DEPTH-1:0] live;
  logic             got_hit;
  logic [PW-1:0]    got_idx, scan_idx;

  assign full_o        = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o       = (cnt_q == '0);
  assign head_pc_o     = ent_q[rd_q].pc;
  assign head_cancel_o = ent_q[rd_q].cancel;
  assign head_exc_o    = ent_q[rd_q].exc;

  // Responses are in order: they belong to the oldest entry still waiting.
  always_comb begin
    got_hit  = 1'b0;
    got_idx  = rd_q;
    scan_idx = rd_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_q + PW'(k);
      if (!got_hit && ((PW+1)'(k) < cnt_q) && !ent_q[scan_idx].data_got) begin
        got_hit = 1'b1;
        got_idx = scan_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i]  = ({1'b0, PW'(i) - rd_q} < cnt_q);
      ent_d[i] = ent_q[i];
      if (cancel_all_i && live[i]) ent_d[i].cancel = 1'b1;
    end
    if (data_ok_i && got_hit) ent_d[got_idx].data_got = 1'b1;
    if (push_i) ent_d[wr_q] = push_ent_i;
    rd_d  = pop_i  ? rd_q + 1'b1 : rd_q;
    wr_d  = push_i ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  a_data_ok_owner: assert property (@(posedge clk) disable iff (rst) data_ok_i |-> got_hit);
  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) push_i |-> (!full_o || pop_i));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the SRAM-like fetch bus, queues
// in-flight PCs and presents the queue head to decode.
// Optional build macro: FETCH_PERFCNT_EN adds perfcnt_addr_wait.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        done_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic        cancelled_o,
  output logic        exc_o,
  output logic [4:0]  exccode_o
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0] perfcnt_addr_wait
`endif
);

  logic [31:0] fpc_q, fpc_d, ppc_q, ppc_d;
  logic        pend_q, pend_d, halt_q, halt_d, first_q;
  logic        full, empty, misal, can_fetch, accept, mis_push, push, pop;
  logic [31:0] head_pc;
  logic        head_cancel, head_exc;
  fq_ent_t     push_ent;

  assign misal     = (fpc_q[1:0] != 2'b00);
  assign can_fetch = !full && !halt_q && !first_q;
  assign inst_req  = can_fetch && !misal;
  assign inst_addr = fpc_q;
  assign accept    = inst_req && inst_addr_ok;
  assign mis_push  = can_fetch && misal;
  assign push      = accept || mis_push;

  assign valid_o     = !empty;
  assign pc_o        = valid_o ? head_pc : 32'h0;
  assign cancelled_o = valid_o && head_cancel;
  assign exc_o       = valid_o && head_exc;
  assign exccode_o   = exc_o ? EXC_ADEL : 5'h00;
  assign pop         = valid_o && done_i && ready_i;

  // An accept that completes a redirected request is already stale.
  always_comb begin
    fpc_d    = fpc_q;
    ppc_d    = ppc_q;
    pend_d   = pend_q;
    halt_d   = halt_q;
    push_ent = fq_make(fpc_q, redirect_i || (accept && pend_q), mis_push);
    if (accept) begin
      fpc_d  = pend_q ? ppc_q : fpc_q + 32'd4;
      pend_d = 1'b0;
    end
    if (mis_push) halt_d = 1'b1;
    if (redirect_i) begin
      halt_d = 1'b0;
      if (inst_req && !inst_addr_ok) begin
        // Bus handshake must complete on the old address first.
        pend_d = 1'b1;
        ppc_d  = redirect_pc_i;
      end else begin
        fpc_d  = redirect_pc_i;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      ppc_q   <= '0;
      pend_q  <= 1'b0;
      halt_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      fpc_q   <= fpc_d;
      ppc_q   <= ppc_d;
      pend_q  <= pend_d;
      halt_q  <= halt_d;
      first_q <= 1'b0;
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic [31:0] pc_wait_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_wait_q <= '0;
    else if (inst_req && !inst_addr_ok) pc_wait_q <= pc_wait_q + 32'd1;
  end
  assign perfcnt_addr_wait = pc_wait_q;
`endif

  fetch_queue #(.DEPTH(DEPTH)) u_fq (
    .clk          (clk),
    .rst          (reset),
    .push_i       (push),
    .push_ent_i   (push_ent),
    .pop_i        (pop),
    .cancel_all_i (redirect_i),
    .data_ok_i    (inst_data_ok),
    .head_pc_o    (head_pc),
    .head_cancel_o(head_cancel),
    .head_exc_o   (head_exc),
    .full_o       (full),
    .empty_o      (empty)
  );

endmodule
